i2c_master_rw: RTL and testbench
================================

// Module: i2c_master_rw
// PURPOSE
//  Parametrised I2C master that runs complete transactions for the TMP101 lab.
//  Sequence: START, 7-bit address + R/W, then a 1-byte write or an N-byte read with master ACK/NACK, then STOP.
//  Replaces the fixed address-byte-only controller/data-unit pair.
//  Sits between user logic (Go/handshake) and the SDA/SCL pins.
// PARAMETERS
//  CLK_FREQ   50  system clock rate, Hz; set 60000000 for hardware
//  I2C_RATE   5   SCL rate, Hz; set 30000 for hardware; must satisfy CLK_FREQ >= 4*I2C_RATE
//  CNT_W      2   width of ByteCount; up to 2**CNT_W-1 read bytes
// PORTS
//  clock        in     1      system clock; all logic on rising edge
//  Reset        in     1      synchronous, active-high
//  Go           in     1      start request; sampled only in IDLE
//  SlaveAddr    in     7      7-bit slave address; latched on accepted Go
//  ReadNotWrite in     1      1 = read, 0 = write; latched on accepted Go
//  ByteCount    in     CNT_W  bytes to read; latched on accepted Go; 0 is treated as 1
//  TxData       in     8      byte sent in a write; latched on accepted Go
//  RxData       out    8      last received byte, MSB first; holds until the next byte completes
//  RxValid      out    1      1-cycle pulse when RxData updates
//  Busy         out    1      high from the cycle after Go is accepted until Done
//  Done         out    1      1-cycle pulse at end of STOP
//  AckError     out    1      slave NACKed; held until the next accepted Go
//  SDA          inout  1      open drain: drives 0 or high-Z, never drives 1
//  SCL          out    1      push-pull; idles high
// BEHAVIOUR
//  Reset: state IDLE; SCL=1; SDA=Z; RxData=0; RxValid=0; Busy=0; Done=0; AckError=0.
//  Reset mid-transaction takes effect on the next edge: bus released immediately, no STOP generated.
//  Timing:
//   - DIV = CLK_FREQ/(4*I2C_RATE), integer-truncated; defaults give DIV = 2.
//   - Each bit slot = 4 quarters of DIV clocks.
//   - Quarters 0-1: SCL=0; SDA changes only at the start of quarter 0.
//   - Quarters 2-3: SCL=1; SDA is sampled on the first clock of quarter 3.
//  States:
//   - IDLE: Go=1 -> START, latch inputs, Busy=1. Go while Busy is ignored.
//   - START (1 slot): SDA falls while SCL is high in quarters 0-1; SCL goes low in quarter 2.
//   - ADDR (8 slots): shifts {SlaveAddr, ReadNotWrite} out MSB first.
//   - ADDR_ACK (1 slot): SDA released and sampled. 1 -> AckError=1, go to STOP. 0 -> WDATA if write, RDATA if read.
//   - WDATA (8 slots): TxData out, MSB first.
//   - WACK (1 slot): sampled 1 -> AckError=1. Always go to STOP.
//   - RDATA (8 slots): SDA released; each sampled bit shifts in at the LSB.
//   - RACK (1 slot): RxValid pulses at the start of this slot.
//     Master drives 0 (ACK) if bytes remain, else releases SDA (NACK) on the last byte.
//     Then RDATA if bytes remain, else STOP.
//   - STOP (1 slot): SDA=0 while SCL rises; SDA released in quarter 3 (rising SDA with SCL high).
//     Next edge: Done=1, Busy=0, IDLE.
//  Total length = (2 + 9*(1+bytes)) slots, where bytes = 1 for a write.
//   - Read of 2 bytes at defaults: 29 slots * 8 clocks = 232 clocks from Go to Done.
//  Remaining-byte counter is CNT_W bits and decrements once per RACK; no wrap past 0.
//  No clock stretching and no arbitration: SCL is never sampled.
//  SDA reads as 1 when high-Z (bench supplies the pull-up).
// TESTING
//  T1: Reset held 3 clocks during ADDR -> SCL=1, SDA=Z, Busy=0 next cycle; no Done pulse.
//  T2: Go with SlaveAddr=0x48, RNW=1, ByteCount=2; slave ACKs and returns 0x19, 0x80
//      -> 0x91 appears on SDA; RxValid pulses with RxData 0x19 then 0x80;
//         master ACKs byte 1 and NACKs byte 2; Done at clock 232; AckError=0.
//  T3: Write, SlaveAddr=0x48, TxData=0x01, slave ACKs both bytes
//      -> SDA shows 0x90 then 0x01; Done after 20 slots (160 clocks).
//  T4: Read to 0x4A with no slave (SDA pulled high) -> AckError=1 after ADDR_ACK;
//      STOP follows; Done at 11 slots (88 clocks); RxValid never pulses.
//  T5: ByteCount=0, read -> exactly one byte read and NACKed; Go pulsed again
//      mid-transaction -> ignored, no restart.
//  Checker on every test: SDA only changes while SCL=0, except during START/STOP;
//      SDA is never driven 1.

Source files
------------

// File: rtl/i2c_master_rw.sv
// I2C master: START, address + R/W, one write byte or N read bytes with master ACK/NACK, STOP.
// Each bit slot is four quarters of DIV clocks; SCL is low in quarters 0-1 and high in quarters 2-3.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | bus released, waiting for Go
// START    | SDA falls with SCL high, then SCL falls
// ADDR     | shift {SlaveAddr, ReadNotWrite} out MSB first
// ADDR_ACK | release SDA, sample slave ACK for the address
// WDATA    | shift the write byte out MSB first
// WACK     | release SDA, sample slave ACK for the write byte
// RDATA    | release SDA, shift sampled bits in at the LSB
// RACK     | master ACK (bytes remain) or NACK (last byte)
// STOP     | SDA low while SCL rises, then SDA released with SCL high
module i2c_master_rw #(
  parameter int CLK_FREQ = 50,
  parameter int I2C_RATE = 5,
  parameter int CNT_W    = 2
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [6:0]       SlaveAddr,
  input  logic             ReadNotWrite,
  input  logic [CNT_W-1:0] ByteCount,
  input  logic [7:0]       TxData,
  output logic [7:0]       RxData,
  output logic             RxValid,
  output logic             Busy,
  output logic             Done,
  output logic             AckError,
  inout  wire              SDA,
  output logic             SCL
);
  localparam int DIV   = CLK_FREQ / (4 * I2C_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       quarter;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_shift, tx_byte, rx_shift, rx_next;
  logic [CNT_W-1:0] bytes_left;
  logic             rnw, sampled, sda_low, sda_in;
  logic             q_end, slot_end, sample_now, bit_now, last_bit, more_bytes;

  assign SDA        = sda_low ? 1'b0 : 1'bz;
  assign sda_in     = SDA;
  assign q_end      = (div_cnt == '0);
  assign slot_end   = q_end && (quarter == 2'd3);
  assign sample_now = (quarter == 2'd3) && (div_cnt == DIV_LOAD);
  // With DIV = 1 the sample and the slot end share a clock, so use the live bit then.
  assign bit_now    = sample_now ? sda_in : sampled;
  assign rx_next    = sample_now ? {rx_shift[6:0], sda_in} : rx_shift;
  assign last_bit   = (bit_cnt == 3'd0);
  assign more_bytes = (bytes_left > CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (Go) state_nxt = S_START;
      S_START:    if (slot_end) state_nxt = S_ADDR;
      S_ADDR:     if (slot_end && last_bit) state_nxt = S_ADDR_ACK;
      S_ADDR_ACK: if (slot_end) state_nxt = bit_now ? S_STOP : (rnw ? S_RDATA : S_WDATA);
      S_WDATA:    if (slot_end && last_bit) state_nxt = S_WACK;
      S_WACK:     if (slot_end) state_nxt = S_STOP;
      S_RDATA:    if (slot_end && last_bit) state_nxt = S_RACK;
      S_RACK:     if (slot_end) state_nxt = more_bytes ? S_RDATA : S_STOP;
      S_STOP:     if (slot_end) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    SCL     = 1'b1;
    sda_low = 1'b0;
    case (state)
      S_START: begin
        SCL     = ~quarter[1];
        sda_low = (quarter != 2'd0);
      end
      S_ADDR, S_WDATA: begin
        SCL     = quarter[1];
        sda_low = ~tx_shift[7];
      end
      S_ADDR_ACK, S_WACK, S_RDATA: SCL = quarter[1];
      S_RACK: begin
        SCL     = quarter[1];
        sda_low = more_bytes;
      end
      S_STOP: begin
        SCL     = quarter[1];
        sda_low = (quarter != 2'd3);
      end
      default: SCL = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      div_cnt    <= DIV_LOAD;
      quarter    <= 2'd0;
      bit_cnt    <= 3'd7;
      tx_shift   <= 8'h00;
      tx_byte    <= 8'h00;
      rx_shift   <= 8'h00;
      bytes_left <= '0;
      rnw        <= 1'b0;
      sampled    <= 1'b1;
      RxData     <= 8'h00;
      RxValid    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      AckError   <= 1'b0;
    end else begin
      state   <= state_nxt;
      RxValid <= 1'b0;
      Done    <= 1'b0;
      if (state == S_IDLE) begin
        div_cnt <= DIV_LOAD;
        quarter <= 2'd0;
        bit_cnt <= 3'd7;
        if (Go) begin
          tx_shift   <= {SlaveAddr, ReadNotWrite};
          tx_byte    <= TxData;
          rnw        <= ReadNotWrite;
          bytes_left <= (ByteCount == '0) ? CNT_W'(1) : ByteCount;
          AckError   <= 1'b0;
          Busy       <= 1'b1;
        end
      end else begin
        div_cnt <= q_end ? DIV_LOAD : div_cnt - 1'b1;
        if (q_end) quarter <= quarter + 1'b1;
        if (sample_now) sampled <= sda_in;
        if (sample_now && state == S_RDATA) rx_shift <= rx_next;
        if (slot_end) begin
          case (state)
            S_ADDR, S_WDATA: begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt - 3'd1;
            end
            S_RDATA: begin
              bit_cnt <= bit_cnt - 3'd1;
              if (last_bit) begin
                RxData  <= rx_next;
                RxValid <= 1'b1;
              end
            end
            S_ADDR_ACK: begin
              tx_shift <= tx_byte;
              if (bit_now) AckError <= 1'b1;
            end
            S_WACK: if (bit_now) AckError <= 1'b1;
            S_RACK: if (bytes_left != '0) bytes_left <= bytes_left - 1'b1;
            S_STOP: begin
              Busy <= 1'b0;
              Done <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_rw.sv
// Scoreboard bench for i2c_master_rw: a behavioural slave at address 0x48 plus a bus decoder;
// expected bus words, read bytes and Done timing are queued by the stimulus and popped by monitors.
module tb_i2c_master_rw;
  localparam int CNT_W = 2;
  localparam logic [6:0] SLV_ADDR = 7'h48;

  logic             clock = 1'b0;
  logic             Reset, Go, ReadNotWrite;
  logic [6:0]       SlaveAddr;
  logic [CNT_W-1:0] ByteCount;
  logic [7:0]       TxData, RxData;
  logic             RxValid, Busy, Done, AckError, SCL;
  wire              sda_bus;
  logic             slave_low = 1'b0;

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_master_rw #(.CLK_FREQ(50), .I2C_RATE(5), .CNT_W(CNT_W)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .SlaveAddr(SlaveAddr),
    .ReadNotWrite(ReadNotWrite), .ByteCount(ByteCount), .TxData(TxData),
    .RxData(RxData), .RxValid(RxValid), .Busy(Busy), .Done(Done),
    .AckError(AckError), .SDA(sda_bus), .SCL(SCL)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0, go_edge = 0;
  logic [7:0] exp_rx[$];
  logic [8:0] exp_bus[$];
  int         exp_clk[$];
  logic       exp_ack[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // DUT output monitor
  logic [7:0] m_rx;
  int         m_clk;
  logic       m_ack;
  always @(negedge clock) begin
    if (!Reset) begin
      if (RxValid) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected actual=%0h required=no_pulse", RxData);
        end else begin
          m_rx = exp_rx.pop_front();
          if (RxData !== m_rx) begin
            errors++;
            $display("FAIL rx_data actual=%0h required=%0h", RxData, m_rx);
          end
        end
      end
      if (Done) begin
        checks++;
        if (exp_clk.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected actual=pulse required=no_pulse");
        end else begin
          m_clk = exp_clk.pop_front();
          m_ack = exp_ack.pop_front();
          if (cyc - go_edge != m_clk) begin
            errors++;
            $display("FAIL done_clocks actual=%0d required=%0d", cyc - go_edge, m_clk);
          end
          chk("ack_error_at_done", AckError, m_ack);
          chk("busy_at_done", Busy, 0);
        end
      end
    end
  end

  // Bus decoder and behavioural slave, evaluated mid-cycle
  logic       scl_prev = 1'b1, sda_prev = 1'b1, bus_idle = 1'b1;
  logic       addr_ok = 1'b0, is_read = 1'b0, sl_done = 1'b0;
  logic [8:0] w9 = '0, m_bus;
  logic [7:0] rd_byte[4];
  int         bitn = 0, pos, bi;
  always @(negedge clock) begin
    if (Reset) begin
      bus_idle = 1'b1; bitn = 0; slave_low = 1'b0;
    end else begin
      if (scl_prev && SCL && (sda_bus != sda_prev)) begin
        checks++;
        if (!sda_bus) begin
          if (!bus_idle) begin
            errors++;
            $display("FAIL start_position actual=mid_txn required=bus_idle");
          end
          bus_idle = 1'b0; bitn = 0; addr_ok = 1'b0; sl_done = 1'b0; slave_low = 1'b0;
        end else begin
          // the STOP's own SCL rise is counted as one extra bit
          if (bitn < 10 || bitn % 9 != 1) begin
            errors++;
            $display("FAIL stop_position actual=%0d required=9n+1", bitn);
          end
          bus_idle = 1'b1; slave_low = 1'b0;
        end
      end else if (!bus_idle && !scl_prev && SCL) begin
        pos = bitn % 9; bi = bitn / 9;
        w9 = {w9[7:0], sda_bus};
        if (bi == 0 && pos == 7) begin
          addr_ok = (w9[7:1] == SLV_ADDR);
          is_read = w9[0];
        end
        if (pos == 8) begin
          checks++;
          if (exp_bus.size() == 0) begin
            errors++;
            $display("FAIL bus_word_unexpected actual=%0h required=none", w9);
          end else begin
            m_bus = exp_bus.pop_front();
            if (w9 !== m_bus) begin
              errors++;
              $display("FAIL bus_word actual=%0h required=%0h", w9, m_bus);
            end
          end
          if (bi >= 1 && is_read && sda_bus) sl_done = 1'b1;
        end
        bitn++;
      end else if (!bus_idle && scl_prev && !SCL) begin
        pos = bitn % 9; bi = bitn / 9;
        slave_low = 1'b0;
        if (addr_ok && !sl_done) begin
          if (pos == 8) slave_low = (bi == 0) || !is_read;
          else if (is_read && bi >= 1) slave_low = ~rd_byte[bi-1][7-pos];
        end
      end
    end
    scl_prev = SCL;
    sda_prev = sda_bus;
  end

  task automatic start_txn(input logic [6:0] a, input logic rnw, input logic [CNT_W-1:0] bc,
                           input logic [7:0] tx);
    @(negedge clock);
    SlaveAddr = a; ReadNotWrite = rnw; ByteCount = bc; TxData = tx; Go = 1'b1;
    go_edge = cyc + 1;
    @(negedge clock);
    Go = 1'b0;
    chk("busy_after_go", Busy, 1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (exp_clk.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_clk.size() != 0) begin
      errors++;
      $display("FAIL done_timeout actual=pending required=done_within_%0d", limit);
      exp_clk.delete(); exp_ack.delete();
    end
    chk("rx_all_seen", exp_rx.size(), 0);
    chk("bus_all_seen", exp_bus.size(), 0);
    exp_rx.delete(); exp_bus.delete();
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; SlaveAddr = '0; ReadNotWrite = 1'b0; ByteCount = '0; TxData = '0;
    rd_byte[0] = 8'h19; rd_byte[1] = 8'h80; rd_byte[2] = 8'h00; rd_byte[3] = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_scl", SCL, 1);
    chk("rst_sda", sda_bus, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_rxvalid", RxValid, 0);
    chk("rst_rxdata", RxData, 0);
    chk("rst_ackerr", AckError, 0);
    Reset = 1'b0;

    // T1: reset during ADDR releases the bus at once, no Done
    start_txn(7'h48, 1'b0, 2'd1, 8'h01);
    repeat (23) @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    chk("t1_scl", SCL, 1);
    chk("t1_sda", sda_bus, 1);
    chk("t1_busy", Busy, 0);
    repeat (2) @(negedge clock);
    Reset = 1'b0;
    repeat (300) @(negedge clock);
    chk("t1_busy_after", Busy, 0);

    // T2: read 2 bytes from 0x48
    exp_bus.push_back({8'h91, 1'b0}); exp_bus.push_back({8'h19, 1'b0}); exp_bus.push_back({8'h80, 1'b1});
    exp_rx.push_back(8'h19); exp_rx.push_back(8'h80);
    exp_clk.push_back(232); exp_ack.push_back(1'b0);
    start_txn(7'h48, 1'b1, 2'd2, 8'h00);
    wait_done(600);

    // T3: write 0x01 to 0x48
    exp_bus.push_back({8'h90, 1'b0}); exp_bus.push_back({8'h01, 1'b0});
    exp_clk.push_back(160); exp_ack.push_back(1'b0);
    start_txn(7'h48, 1'b0, 2'd1, 8'h01);
    wait_done(600);

    // T4: read from absent 0x4A
    exp_bus.push_back({8'h95, 1'b1});
    exp_clk.push_back(88); exp_ack.push_back(1'b1);
    start_txn(7'h4A, 1'b1, 2'd1, 8'h00);
    wait_done(600);
    repeat (5) @(negedge clock);
    chk("t4_ackerr_held", AckError, 1);

    // T5: ByteCount 0 reads one byte; a second Go mid-transaction is ignored
    rd_byte[0] = 8'hA5;
    exp_bus.push_back({8'h91, 1'b0}); exp_bus.push_back({8'hA5, 1'b1});
    exp_rx.push_back(8'hA5);
    exp_clk.push_back(160); exp_ack.push_back(1'b0);
    start_txn(7'h48, 1'b1, 2'd0, 8'h00);
    repeat (40) @(negedge clock);
    SlaveAddr = 7'h10; ReadNotWrite = 1'b0; Go = 1'b1;
    @(negedge clock);
    Go = 1'b0;
    wait_done(600);
    repeat (200) @(negedge clock);
    chk("t5_busy_idle", Busy, 0);
    chk("t5_scl_idle", SCL, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
